sh7034_itu_irq_arb: RTL and testbench
=====================================

# sh7034_itu_irq_arb

Interrupt request arbiter for the 15 ITU interrupt sources (IMIA/IMIB/OVI of channels 0–4).

- Holds a programmable 4-bit priority level per ITU channel, mapped as an on-chip register on IBUS.
- Picks the single highest-priority pending source and presents its level and vector to the CPU interrupt controller.
- Sequences the request/acknowledge handshake, then masks re-requests for a short hold window so the ISR can clear the TSR flag.
- Sits between the ITU IRQ outputs and the CPU interrupt input.

## Interface
Parameters:
- BASE_VEC, 80: vector number of ITU0 IMIA. Vector = BASE_VEC + 4·ch + src, where src is IMIA=0, IMIB=1, OVI=2.
- HOLD_CYC, 2: number of CE_R cycles the block stays in HOLD after an acknowledge (1–15).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset; synchronous, active-low, sampled on CLK rising edge regardless of CE_R.
- CE_R  in  1  clock enable; all state advances only when high.
- IMIA_IRQ  in  5  level requests from the ITU, bit = channel.
- IMIB_IRQ  in  5  level requests from the ITU.
- OVI_IRQ  in  5  level requests from the ITU.
- IBUS_A  in  28  byte address.
- IBUS_DI  in  32  write data.
- IBUS_DO  out  32  read data.
- IBUS_BA  in  4  byte-lane enables; [3] = bits 31:24.
- IBUS_WE  in  1  write strobe.
- IBUS_REQ  in  1  access request.
- IBUS_BUSY  out  1  always 0.
- IBUS_ACT  out  1  high when the register is selected.
- INT_REQ  out  1  interrupt request to the CPU.
- INT_LVL  out  4  level of the presented request.
- INT_VEC  out  8  vector of the presented request.
- INT_ACK  in  1  one-CE_R-cycle acknowledge from the CPU.
- ACK_SRC  out  15  one-hot pulse marking the acknowledged source. Bit index is 3·ch + src.

## Operation
Register ITUPR:
- Single 32-bit word at 0x5FFFF88 (address bits 27:2 match). IBUS_ACT is high when selected.
- Channel level fields: [19:16] ch0, [15:12] ch1, [11:8] ch2, [7:4] ch3, [3:0] ch4. All other bits read 0 and ignore writes.
- Writes occur when IBUS_REQ & IBUS_WE & CE_R, per byte lane.
- Reads return the register when selected with IBUS_REQ & !IBUS_WE, registered on CE_R. IBUS_DO = 0 when not selected.
- Reset value is 0.

Arbitration (combinational over the inputs and ITUPR):
- Candidate = any asserted source whose channel level is nonzero. Level 0 disables the channel.
- Winner = highest level. Ties go to the lower channel, then IMIA > IMIB > OVI.

State machine, evaluated on CE_R:
- IDLE: if a candidate exists, latch its LVL/VEC/source into the output registers, set INT_REQ=1 and go to REQ.
- REQ: each CE_R the winner is re-evaluated.
  - If INT_ACK=1: emit the ACK_SRC pulse for the latched source, clear INT_REQ, load the hold counter with HOLD_CYC−1 and go to HOLD. This has priority over preemption and drop in the same cycle.
  - Else, if the winner's level is strictly greater than INT_LVL, replace LVL/VEC/source (preemption).
  - Else, if the latched source is no longer asserted or its channel level is 0:
    - a remaining candidate is reloaded as the new winner;
    - with no candidate, INT_REQ=0 and the block returns to IDLE.
- HOLD: INT_REQ=0. The counter decrements each CE_R; when it reaches 0, go to IDLE. INT_ACK is ignored here.
- Rewriting ITUPR while in REQ takes effect at the next evaluation, via the drop and preempt rules.

Reset:
- State IDLE.
- INT_REQ=0, INT_LVL=0, INT_VEC=0, ACK_SRC=0, IBUS_DO=0, ITUPR=0, hold counter 0.

## Timing
- Request latency: a source rising in CE_R cycle n, with level > 0, gives INT_REQ=1 with valid LVL/VEC after the CLK edge ending cycle n, i.e. visible in cycle n+1.
- INT_LVL and INT_VEC are stable whenever INT_REQ=1. They change only on preemption or reload, always on a CE_R edge.
- ACK_SRC is high for exactly one CE_R cycle, the one after INT_ACK is sampled. It is 0 in all other cycles.
- After an acknowledge, INT_REQ stays low for HOLD_CYC CE_R cycles. The earliest re-request appears HOLD_CYC+1 cycles after the ACK cycle.
- A write to ITUPR is used by the arbitration in the following CE_R cycle.
- An ITUPR read returns data on the CE_R edge after the request and holds it until the next read.
- With CE_R=0, all outputs hold. A reset mid-handshake returns to IDLE immediately and drops INT_REQ.

## Test plan
- Basic request and acknowledge:
  - Stimulus: ITUPR=0x00030000, pulse IMIA_IRQ[0] high.
  - Response: next cycle INT_REQ=1, INT_LVL=3, INT_VEC=80.
  - Then INT_ACK: ACK_SRC bit0 pulses, INT_REQ=0 for 2 cycles, and it re-asserts if IMIA_IRQ[0] is still high.
- Tie-break:
  - Stimulus: ch1 and ch3 both at level 5; assert OVI_IRQ[3], IMIB_IRQ[1], IMIA_IRQ[1] together.
  - Response: INT_VEC=84 (ch1 IMIA).
- Preemption:
  - Stimulus: in REQ with ch4 level 2 (OVI4, VEC=98), assert IMIA_IRQ[2] with level 7.
  - Response: next cycle INT_LVL=7, INT_VEC=88, INT_REQ stays 1.
  - Then assert an equal-level request.
  - Response: no change.
- Drop and disable:
  - Stimulus: in REQ, clear the latched source's input, with no other request pending.
  - Response: INT_REQ=0, back to IDLE.
  - Stimulus: ITUPR level 0 for an asserted channel.
  - Response: no request is ever raised.
- Simultaneous events:
  - Stimulus: INT_ACK coincides with a higher-level arrival.
  - Response: the acknowledge wins (ACK_SRC is the old source); the new source is presented after HOLD.
- Register bus and reset:
  - Stimulus: byte write BA=0100, DI=0x000A0000.
  - Response: ITUPR reads 0x000A0000.
  - Stimulus: write 0xFFFFFFFF.
  - Response: reads 0x000FFFFF.
  - Stimulus: RST_N low during HOLD.
  - Response: all outputs and ITUPR are 0 on the next edge.

Source files
------------

// File: rtl/sh7034_itu_irq_arb.sv
// Interrupt request arbiter for the 15 ITU sources (IMIA/IMIB/OVI of channels 0-4).
// Holds the ITUPR priority register, selects one winner and runs the CPU request/ack handshake.
module sh7034_itu_irq_arb #(
  parameter int BASE_VEC = 80,
  parameter int HOLD_CYC = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic [4:0]  IMIA_IRQ,
  input  logic [4:0]  IMIB_IRQ,
  input  logic [4:0]  OVI_IRQ,
  input  logic [27:0] IBUS_A,
  input  logic [31:0] IBUS_DI,
  output logic [31:0] IBUS_DO,
  input  logic [3:0]  IBUS_BA,
  input  logic        IBUS_WE,
  input  logic        IBUS_REQ,
  output logic        IBUS_BUSY,
  output logic        IBUS_ACT,
  output logic        INT_REQ,
  output logic [3:0]  INT_LVL,
  output logic [7:0]  INT_VEC,
  input  logic        INT_ACK,
  output logic [14:0] ACK_SRC
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [25:0] ITUPR_WADDR = 26'h17FFFE2;  // 0x5FFFF88 >> 2
  localparam logic [3:0]  HOLD_LOAD   = 4'(HOLD_CYC - 1);

  state_e      state_q, state_d;
  logic [19:0] itupr_q, itupr_d;
  logic [31:0] do_q, do_d;
  logic        req_q, req_d;
  logic [3:0]  lvl_q, lvl_d;
  logic [7:0]  vec_q, vec_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  hold_q, hold_d;
  logic [14:0] ack_q, ack_d;

  logic        sel;
  logic [3:0]  ch_lvl [5];
  logic [14:0] src_pend;
  logic        win_vld;
  logic [3:0]  win_lvl;
  logic [3:0]  win_idx;
  logic [2:0]  win_ch;
  logic [1:0]  win_s;
  logic [7:0]  win_vec;
  logic        load;

  // ---------------------------------------------------------------- register bus
  assign sel = IBUS_REQ && (IBUS_A[27:2] == ITUPR_WADDR);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    itupr_d = itupr_q;
    do_d    = do_q;
    if (sel && IBUS_WE) begin
      if (IBUS_BA[2]) itupr_d[19:16] = IBUS_DI[19:16];
      if (IBUS_BA[1]) itupr_d[15:8]  = IBUS_DI[15:8];
      if (IBUS_BA[0]) itupr_d[7:0]   = IBUS_DI[7:0];
    end
    // Any read cycle refreshes the data register; reads of other addresses return 0.
    if (IBUS_REQ && !IBUS_WE) begin
      do_d = sel ? {12'd0, itupr_q} : 32'd0;
    end
  end

  // ---------------------------------------------------------------- arbitration
  always_comb begin
    src_pend = '0;
    for (int ch = 0; ch < 5; ch++) begin
      ch_lvl[ch]       = itupr_q[19-4*ch -: 4];
      src_pend[3*ch]   = IMIA_IRQ[ch] && (ch_lvl[ch] != 4'd0);
      src_pend[3*ch+1] = IMIB_IRQ[ch] && (ch_lvl[ch] != 4'd0);
      src_pend[3*ch+2] = OVI_IRQ[ch]  && (ch_lvl[ch] != 4'd0);
    end
  end

  // Ascending scan with strict '>' keeps the lowest source index on level ties.
  always_comb begin
    win_vld = 1'b0;
    win_lvl = 4'd0;
    win_idx = 4'd0;
    win_ch  = 3'd0;
    win_s   = 2'd0;
    for (int ch = 0; ch < 5; ch++) begin
      for (int s = 0; s < 3; s++) begin
        if (src_pend[3*ch+s] && (!win_vld || (ch_lvl[ch] > win_lvl))) begin
          win_vld = 1'b1;
          win_lvl = ch_lvl[ch];
          win_idx = 4'(3*ch + s);
          win_ch  = 3'(ch);
          win_s   = 2'(s);
        end
      end
    end
    win_vec = 8'(BASE_VEC) + 8'({win_ch, 2'b00}) + 8'(win_s);
  end

  // ---------------------------------------------------------------- handshake FSM
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    lvl_d   = lvl_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    ack_d   = '0;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_vld) load = 1'b1;
      end
      ST_REQ: begin
        if (INT_ACK) begin
          ack_d   = 15'(1) << idx_q;
          req_d   = 1'b0;
          hold_d  = HOLD_LOAD;
          state_d = ST_HOLD;
        end else if (win_vld && (win_lvl > lvl_q)) begin
          load = 1'b1;
        end else if (!src_pend[idx_q]) begin
          if (win_vld) begin
            load = 1'b1;
          end else begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        // The last hold cycle also does the idle evaluation, so INT_REQ is low
        // for exactly HOLD_CYC cycles before a pending source is re-presented.
        if (hold_q == 4'd0) begin
          if (win_vld) load = 1'b1;
          else         state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d = ST_REQ;
      req_d   = 1'b1;
      lvl_d   = win_lvl;
      vec_d   = win_vec;
      idx_d   = win_idx;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      itupr_q <= '0;
      do_q    <= '0;
      req_q   <= 1'b0;
      lvl_q   <= '0;
      vec_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      ack_q   <= '0;
    end else if (CE_R) begin
      state_q <= state_d;
      itupr_q <= itupr_d;
      do_q    <= do_d;
      req_q   <= req_d;
      lvl_q   <= lvl_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      ack_q   <= ack_d;
    end
  end

  assign IBUS_DO   = do_q;
  assign IBUS_BUSY = 1'b0;
  assign IBUS_ACT  = sel;
  assign INT_REQ   = req_q;
  assign INT_LVL   = lvl_q;
  assign INT_VEC   = vec_q;
  assign ACK_SRC   = ack_q;

endmodule

// File: tb/tb_sh7034_itu_irq_arb.sv
// Self-checking bench for sh7034_itu_irq_arb: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the arbiter.
module tb_sh7034_itu_irq_arb;

  localparam int          BASE_VEC   = 80;
  localparam int          HOLD_CYC   = 2;
  localparam logic [27:0] ITUPR_ADDR = 28'h5FFFF88;

  logic        CLK = 1'b0;
  logic        RST_N, CE_R;
  logic [4:0]  IMIA_IRQ, IMIB_IRQ, OVI_IRQ;
  logic [27:0] IBUS_A;
  logic [31:0] IBUS_DI, IBUS_DO;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE, IBUS_REQ, IBUS_BUSY, IBUS_ACT;
  logic        INT_REQ, INT_ACK;
  logic [3:0]  INT_LVL;
  logic [7:0]  INT_VEC;
  logic [14:0] ACK_SRC;

  int checks   = 0;
  int failures = 0;

  sh7034_itu_irq_arb #(.BASE_VEC(BASE_VEC), .HOLD_CYC(HOLD_CYC)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R),
    .IMIA_IRQ(IMIA_IRQ), .IMIB_IRQ(IMIB_IRQ), .OVI_IRQ(OVI_IRQ),
    .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
    .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
    .INT_REQ(INT_REQ), .INT_LVL(INT_LVL), .INT_VEC(INT_VEC), .INT_ACK(INT_ACK),
    .ACK_SRC(ACK_SRC)
  );

  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------- reference model
  // mode: 0 idle, 1 presenting a request, 2 hold after acknowledge
  int          m_mode, m_hold_left, m_lvl, m_vec, m_src;
  bit          m_req;
  logic [14:0] m_ack;
  logic [19:0] m_itupr;
  logic [31:0] m_do;

  function automatic int lvl_of(int ch);
    return int'((m_itupr >> (16 - 4*ch)) & 20'hF);
  endfunction

  function automatic bit src_in(int idx);
    case (idx % 3)
      0:       return IMIA_IRQ[idx/3];
      1:       return IMIB_IRQ[idx/3];
      default: return OVI_IRQ[idx/3];
    endcase
  endfunction

  function automatic int model_winner();
    int w = -1;
    int best = 0;
    for (int idx = 0; idx < 15; idx++)
      if (src_in(idx) && lvl_of(idx/3) > best) begin
        best = lvl_of(idx/3);
        w = idx;
      end
    return w;
  endfunction

  function automatic void model_present(int w);
    m_req  = 1'b1;
    m_lvl  = lvl_of(w/3);
    m_vec  = BASE_VEC + 4*(w/3) + (w%3);
    m_src  = w;
    m_mode = 1;
  endfunction

  function automatic void model_step();
    int w;
    logic [14:0] new_ack = '0;
    logic [31:0] lane;
    if (!RST_N) begin
      m_mode = 0; m_hold_left = 0; m_req = 0; m_lvl = 0; m_vec = 0; m_src = 0;
      m_ack = '0; m_itupr = '0; m_do = '0;
      return;
    end
    if (!CE_R) return;
    w = model_winner();
    case (m_mode)
      0: if (w >= 0) model_present(w);
      1: begin
        if (INT_ACK) begin
          new_ack[m_src] = 1'b1;
          m_req = 0; m_mode = 2; m_hold_left = HOLD_CYC;
        end else if (w >= 0 && lvl_of(w/3) > m_lvl) begin
          model_present(w);
        end else if (!(src_in(m_src) && lvl_of(m_src/3) > 0)) begin
          if (w >= 0) model_present(w);
          else begin m_req = 0; m_mode = 0; end
        end
      end
      default: begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          if (w >= 0) model_present(w);
          else m_mode = 0;
        end
      end
    endcase
    m_ack = new_ack;
    if (IBUS_REQ && !IBUS_WE)
      m_do = (IBUS_A[27:2] == ITUPR_ADDR[27:2]) ? {12'd0, m_itupr} : 32'd0;
    if (IBUS_REQ && IBUS_WE && IBUS_A[27:2] == ITUPR_ADDR[27:2]) begin
      lane = {{8{IBUS_BA[3]}}, {8{IBUS_BA[2]}}, {8{IBUS_BA[1]}}, {8{IBUS_BA[0]}}} & 32'h000FFFFF;
      m_itupr = 20'((({12'd0, m_itupr}) & ~lane) | (IBUS_DI & lane));
    end
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 0; CE_R = 1; INT_ACK = 0;
    IMIA_IRQ = 0; IMIB_IRQ = 0; OVI_IRQ = 0;
    IBUS_REQ = 0; IBUS_WE = 0; IBUS_A = 0; IBUS_DI = 0; IBUS_BA = 0;
    tick();
    RST_N = 1;
  endtask

  task automatic bus_write(input logic [31:0] d, input logic [3:0] ba);
    IBUS_REQ = 1; IBUS_WE = 1; IBUS_A = ITUPR_ADDR; IBUS_DI = d; IBUS_BA = ba;
    tick();
    IBUS_REQ = 0; IBUS_WE = 0; IBUS_DI = 0; IBUS_BA = 0;
  endtask

  task automatic bus_read(input logic [27:0] a);
    IBUS_REQ = 1; IBUS_WE = 0; IBUS_A = a;
    tick();
    IBUS_REQ = 0;
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    do_reset();
    checks++; if (INT_REQ !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", INT_REQ); end
    checks++; if (INT_LVL !== 4'd0) begin failures++; $display("FAIL reset_lvl got=%0d exp=0", INT_LVL); end
    checks++; if (INT_VEC !== 8'd0) begin failures++; $display("FAIL reset_vec got=%0d exp=0", INT_VEC); end
    checks++; if (ACK_SRC !== 15'd0) begin failures++; $display("FAIL reset_ack got=%h exp=0", ACK_SRC); end
    checks++; if (IBUS_DO !== 32'd0) begin failures++; $display("FAIL reset_do got=%h exp=0", IBUS_DO); end
    checks++; if (IBUS_BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", IBUS_BUSY); end
  endtask

  task automatic test_basic();
    do_reset();
    bus_write(32'h00030000, 4'b0100);
    IMIA_IRQ = 5'b00001;
    tick();
    checks++; if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd3, 8'd80}) begin failures++;
      $display("FAIL basic_req got=%b/%0d/%0d exp=1/3/80", INT_REQ, INT_LVL, INT_VEC); end
    INT_ACK = 1;
    tick();
    INT_ACK = 0;
    checks++; if ({INT_REQ, ACK_SRC} !== {1'b0, 15'h0001}) begin failures++;
      $display("FAIL basic_ack got=%b/%h exp=0/0001", INT_REQ, ACK_SRC); end
    tick();
    checks++; if ({INT_REQ, ACK_SRC} !== {1'b0, 15'h0000}) begin failures++;
      $display("FAIL basic_hold got=%b/%h exp=0/0000", INT_REQ, ACK_SRC); end
    tick();
    checks++; if ({INT_REQ, INT_VEC} !== {1'b1, 8'd80}) begin failures++;
      $display("FAIL basic_rereq got=%b/%0d exp=1/80", INT_REQ, INT_VEC); end
    IMIA_IRQ = 0;
    tick();
    checks++; if (INT_REQ !== 1'b0) begin failures++; $display("FAIL basic_drop got=%b exp=0", INT_REQ); end
  endtask

  task automatic test_tiebreak();
    do_reset();
    bus_write(32'h00005050, 4'b0011);
    OVI_IRQ = 5'b01000; IMIB_IRQ = 5'b00010; IMIA_IRQ = 5'b00010;
    tick();
    checks++; if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd5, 8'd84}) begin failures++;
      $display("FAIL tie_vec got=%b/%0d/%0d exp=1/5/84", INT_REQ, INT_LVL, INT_VEC); end
  endtask

  task automatic test_preempt();
    do_reset();
    bus_write(32'h00000702, 4'b0011);
    OVI_IRQ = 5'b10000;
    tick();
    checks++; if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd2, 8'd98}) begin failures++;
      $display("FAIL pre_first got=%b/%0d/%0d exp=1/2/98", INT_REQ, INT_LVL, INT_VEC); end
    IMIA_IRQ = 5'b00100;
    tick();
    checks++; if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd7, 8'd88}) begin failures++;
      $display("FAIL pre_higher got=%b/%0d/%0d exp=1/7/88", INT_REQ, INT_LVL, INT_VEC); end
    bus_write(32'h00070000, 4'b0100);
    IMIA_IRQ = 5'b00101;
    tick();
    checks++; if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd7, 8'd88}) begin failures++;
      $display("FAIL pre_equal got=%b/%0d/%0d exp=1/7/88", INT_REQ, INT_LVL, INT_VEC); end
  endtask

  task automatic test_drop_disable();
    do_reset();
    bus_write(32'h00030000, 4'b0100);
    IMIB_IRQ = 5'b00001;
    tick();
    checks++; if ({INT_REQ, INT_VEC} !== {1'b1, 8'd81}) begin failures++;
      $display("FAIL drop_req got=%b/%0d exp=1/81", INT_REQ, INT_VEC); end
    IMIB_IRQ = 0;
    tick();
    checks++; if (INT_REQ !== 1'b0) begin failures++; $display("FAIL drop_idle got=%b exp=0", INT_REQ); end
    IMIA_IRQ = 5'b00010; IMIB_IRQ = 5'b00010; OVI_IRQ = 5'b00010;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (INT_REQ !== 1'b0) begin failures++; $display("FAIL disabled_ch got=%b exp=0", INT_REQ); end
    end
    // Disabling the latched channel while another is pending reloads the other one.
    IMIA_IRQ = 5'b01001; IMIB_IRQ = 0; OVI_IRQ = 0;
    tick();
    checks++; if ({INT_REQ, INT_VEC} !== {1'b1, 8'd80}) begin failures++;
      $display("FAIL reload_pre got=%b/%0d exp=1/80", INT_REQ, INT_VEC); end
    bus_write(32'h00000010, 4'b0111);
    tick();
    checks++; if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd1, 8'd92}) begin failures++;
      $display("FAIL reload got=%b/%0d/%0d exp=1/1/92", INT_REQ, INT_LVL, INT_VEC); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus_write(32'h00000702, 4'b0011);
    OVI_IRQ = 5'b10000;
    tick();
    INT_ACK = 1; IMIA_IRQ = 5'b00100;
    tick();
    INT_ACK = 0;
    checks++; if ({INT_REQ, ACK_SRC} !== {1'b0, 15'h4000}) begin failures++;
      $display("FAIL sim_ack got=%b/%h exp=0/4000", INT_REQ, ACK_SRC); end
    tick();
    checks++; if (INT_REQ !== 1'b0) begin failures++; $display("FAIL sim_hold got=%b exp=0", INT_REQ); end
    tick();
    checks++; if ({INT_REQ, INT_LVL, INT_VEC} !== {1'b1, 4'd7, 8'd88}) begin failures++;
      $display("FAIL sim_after got=%b/%0d/%0d exp=1/7/88", INT_REQ, INT_LVL, INT_VEC); end
  endtask

  task automatic test_regbus();
    do_reset();
    IBUS_REQ = 1; IBUS_WE = 0; IBUS_A = ITUPR_ADDR;
    #1;
    checks++; if (IBUS_ACT !== 1'b1) begin failures++; $display("FAIL act_sel got=%b exp=1", IBUS_ACT); end
    IBUS_A = ITUPR_ADDR + 28'd4;
    #1;
    checks++; if (IBUS_ACT !== 1'b0) begin failures++; $display("FAIL act_other got=%b exp=0", IBUS_ACT); end
    IBUS_REQ = 0;
    bus_write(32'h000A0000, 4'b0100);
    bus_read(ITUPR_ADDR);
    tick();
    checks++; if (IBUS_DO !== 32'h000A0000) begin failures++; $display("FAIL rd_byte got=%h exp=000a0000", IBUS_DO); end
    bus_write(32'hFFFFFFFF, 4'b1111);
    bus_read(ITUPR_ADDR);
    checks++; if (IBUS_DO !== 32'h000FFFFF) begin failures++; $display("FAIL rd_all got=%h exp=000fffff", IBUS_DO); end
    CE_R = 0;
    bus_write(32'h00000000, 4'b1111);
    CE_R = 1;
    bus_read(ITUPR_ADDR);
    checks++; if (IBUS_DO !== 32'h000FFFFF) begin failures++; $display("FAIL ce_write got=%h exp=000fffff", IBUS_DO); end
    bus_read(ITUPR_ADDR + 28'd4);
    checks++; if (IBUS_DO !== 32'h0) begin failures++; $display("FAIL rd_other got=%h exp=0", IBUS_DO); end
  endtask

  task automatic test_ce_hold();
    do_reset();
    bus_write(32'h00030000, 4'b0100);
    IMIA_IRQ = 5'b00001;
    tick();
    CE_R = 0; INT_ACK = 1;
    tick(); tick();
    checks++; if ({INT_REQ, ACK_SRC} !== {1'b1, 15'h0}) begin failures++;
      $display("FAIL ce_stall got=%b/%h exp=1/0000", INT_REQ, ACK_SRC); end
    CE_R = 1;
    tick();
    CE_R = 0; INT_ACK = 0;
    tick();
    checks++; if ({INT_REQ, ACK_SRC} !== {1'b0, 15'h0001}) begin failures++;
      $display("FAIL ce_ackhold got=%b/%h exp=0/0001", INT_REQ, ACK_SRC); end
    // Reset while stalled in HOLD still clears everything.
    RST_N = 0;
    tick();
    RST_N = 1; CE_R = 1;
    checks++; if ({INT_REQ, INT_LVL, INT_VEC, ACK_SRC} !== '0) begin failures++;
      $display("FAIL rst_hold got=%b/%0d/%0d/%h exp=0/0/0/0", INT_REQ, INT_LVL, INT_VEC, ACK_SRC); end
    IMIA_IRQ = 0;
    bus_read(ITUPR_ADDR);
    checks++; if (IBUS_DO !== 32'h0) begin failures++; $display("FAIL rst_itupr got=%h exp=0", IBUS_DO); end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(3) == 0) begin
        r = $urandom_range(14);
        case (r % 3)
          0: IMIA_IRQ[r/3] = ~IMIA_IRQ[r/3];
          1: IMIB_IRQ[r/3] = ~IMIB_IRQ[r/3];
          default: OVI_IRQ[r/3] = ~OVI_IRQ[r/3];
        endcase
      end
      INT_ACK = ($urandom_range(4) == 0);
      CE_R    = ($urandom_range(7) != 0);
      RST_N   = ($urandom_range(499) != 0);
      r = $urandom_range(39);
      IBUS_REQ = (r < 8);
      IBUS_WE  = (r < 4);
      IBUS_A   = (r == 7) ? ITUPR_ADDR ^ 28'h10 : ITUPR_ADDR;
      IBUS_DI  = $urandom;
      IBUS_BA  = 4'($urandom);
      tick();
      checks++; if (INT_REQ !== m_req) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, INT_REQ, m_req); end
      checks++; if (INT_LVL !== 4'(m_lvl)) begin failures++; $display("FAIL rnd_lvl cyc=%0d got=%0d exp=%0d", cyc, INT_LVL, m_lvl); end
      checks++; if (INT_VEC !== 8'(m_vec)) begin failures++; $display("FAIL rnd_vec cyc=%0d got=%0d exp=%0d", cyc, INT_VEC, m_vec); end
      checks++; if (ACK_SRC !== m_ack) begin failures++; $display("FAIL rnd_ack cyc=%0d got=%h exp=%h", cyc, ACK_SRC, m_ack); end
      checks++; if (IBUS_DO !== m_do) begin failures++; $display("FAIL rnd_do cyc=%0d got=%h exp=%h", cyc, IBUS_DO, m_do); end
    end
    RST_N = 1; CE_R = 1; INT_ACK = 0; IBUS_REQ = 0; IBUS_WE = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tiebreak();
    test_preempt();
    test_drop_disable();
    test_simultaneous();
    test_regbus();
    test_ce_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
